// File: rtl/demux2_stream_pkg.sv
// rtl/demux2_stream_pkg.sv - shared select encodings and datapath defaults for demux2_stream
package demux2_stream_pkg;

    localparam logic DEST_0 = 1'b0;
    localparam logic DEST_1 = 1'b1;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

endpackage

// File: rtl/demux2_stream_sync_fifo_rv.sv
// rtl/demux2_stream_sync_fifo_rv.sv - synchronous ready/valid FIFO with occupancy count
module sync_fifo_rv #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // A full FIFO refuses the push even when it pops in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Masking with empty keeps the head at zero during and after reset.
    assign head_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - one-source two-sink demultiplexer with a FIFO per destination
module demux2_stream
    import demux2_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNTW-1:0]  count0,
    output logic [CNTW-1:0]  count1
);

    logic                  sel1;
    logic                  accept;
    logic                  full0, full1;
    logic                  empty0, empty1;
    logic [$clog2(DEPTH):0] cnt0, cnt1;

    assign sel1     = (in_sel == DEST_1);
    // Readiness looks only at the selected FIFO, never at in_valid.
    assign in_ready = sel1 ? ~full1 : ~full0;
    assign accept   = in_valid & in_ready;

    sync_fifo_rv #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept & ~sel1),
        .push_data (in_data),
        .full      (full0),
        .pop       (out0_ready),
        .head_data (out0_data),
        .empty     (empty0),
        .count     (cnt0)
    );

    sync_fifo_rv #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept & sel1),
        .push_data (in_data),
        .full      (full1),
        .pop       (out1_ready),
        .head_data (out1_data),
        .empty     (empty1),
        .count     (cnt1)
    );

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;
    assign count0     = CNTW'(cnt0);
    assign count1     = CNTW'(cnt1);

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - randomized scoreboard bench for demux2_stream
`timescale 1ns/1ps
module tb_demux2_stream;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNTW  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sel = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out0_valid, out1_valid;
    logic             out0_ready = 1'b0, out1_ready = 1'b0;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic [CNTW-1:0]  count0, count1;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    always #10 clk = ~clk;

    demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .count0     (count0),
        .count1     (count1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compares registered outputs against the queue model, then retires popped heads.
    always @(negedge clk) begin
        #2;
        chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
        chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
        chk("count0", 32'(count0), 32'(q0.size()));
        chk("count1", 32'(count1), 32'(q1.size()));
        if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
        if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
        if (rst_n && q0.size() != 0 && out0_ready) void'(q0.pop_front());
        if (rst_n && q1.size() != 0 && out1_ready) void'(q1.pop_front());
    end

    // Driver: applies one cycle of stimulus and pushes the expected word on accept.
    task automatic cycle(input logic v, input logic s, input logic [31:0] d,
                         input logic r0, input logic r1);
        logic exp_ready;
        logic acc;
        @(negedge clk);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        exp_ready = s ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready && rst_n;
        #2;
        if (acc) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #5;
        rst_n = 1'b0;
        #1;
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("rst_count0", 32'(count0), 32'd0);
        chk("rst_count1", 32'(count1), 32'd0);
        chk("rst_out0_data", out0_data, 32'd0);
        chk("rst_out1_data", out1_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #7;
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        chk("por_count0", 32'(count0), 32'd0);
        chk("por_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #7;
        rst_n = 1'b1;

        // Fill with consumers stalled.
        cycle(1, 0, 32'hA1, 0, 0);
        cycle(1, 1, 32'hB1, 0, 0);
        cycle(1, 0, 32'hA2, 0, 0);
        cycle(0, 1, 32'h0, 0, 0);
        cycle(0, 0, 32'h0, 0, 0);
        // Full FIFO0 refuses while popping, then accepts.
        cycle(1, 0, 32'hA3, 1, 0);
        cycle(1, 0, 32'hA3, 0, 0);
        // Empty FIFO1, then toggle select while FIFO0 is full.
        cycle(0, 0, 32'h0, 0, 1);
        cycle(1, 0, 32'hC1, 0, 0);
        cycle(1, 1, 32'hC1, 0, 0);
        cycle(1, 0, 32'hC2, 0, 0);
        // Counts (1,2) then push FIFO0 while popping FIFO1.
        cycle(0, 0, 32'h0, 1, 0);
        cycle(1, 1, 32'hC3, 0, 0);
        cycle(1, 0, 32'hD1, 0, 1);
        cycle(0, 0, 32'h0, 0, 0);
        // Drain, then stream through FIFO1.
        repeat (4) cycle(0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 8; i++) cycle(1, 1, 32'h10 + 32'(i), 0, 1);
        repeat (2) cycle(0, 1, 32'h0, 0, 1);
        // Asynchronous reset with both FIFOs occupied.
        cycle(1, 0, 32'hE1, 0, 0);
        cycle(1, 1, 32'hE2, 0, 0);
        cycle(1, 0, 32'hE3, 0, 0);
        async_reset();
        cycle(1, 0, 32'h55, 0, 0);
        cycle(0, 0, 32'h0, 1, 0);
        cycle(0, 0, 32'h0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end
        repeat (4) cycle(0, 0, 32'h0, 1, 1);
        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
